// File: rtl/cntnet_seq_cnt.sv
// Phase/step sequencer: on start, sweeps cnt FIRST..LAST, PASSES times, stepping only when en is high.
// Optional sticky restart-while-busy flag: define CNTNET_SEQ_CNT_OVERRUN_EN.
module cntnet_seq_cnt #(
    parameter int WIDTH  = 3,
    parameter int FIRST  = 1,
    parameter int LAST   = 7,
    parameter int PASSES = 1,
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              en,
    output logic [WIDTH-1:0]  cnt,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              last,
    output logic              done
`ifdef CNTNET_SEQ_CNT_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam logic [WIDTH-1:0]  FIRST_V   = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0]  LAST_V    = WIDTH'(LAST);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

    if (FIRST < 1 || FIRST > LAST || LAST > (2**WIDTH) - 1 || PASSES < 1) begin : g_bad_params
        $error("cntnet_seq_cnt: illegal parameters WIDTH=%0d FIRST=%0d LAST=%0d PASSES=%0d",
               WIDTH, FIRST, LAST, PASSES);
    end

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pass_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            // Restart from any state, including the final-step cycle, which suppresses done.
            state    <= RUN;
            cnt      <= FIRST_V;
            pass_idx <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    pass_idx <= '0;
                    busy     <= 1'b0;
                end
                RUN: begin
                    if (en) begin
                        if (cnt < LAST_V) begin
                            cnt <= cnt + 1'b1;
                        end else if (pass_idx != PASS_LAST) begin
                            cnt      <= FIRST_V;
                            pass_idx <= pass_idx + 1'b1;
                        end else begin
                            state    <= IDLE;
                            cnt      <= '0;
                            pass_idx <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    pass_idx <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign last = busy && (cnt == LAST_V) && (pass_idx == PASS_LAST);

`ifdef CNTNET_SEQ_CNT_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset)
            overrun <= 1'b0;
        else if (start && busy)
            overrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_cntnet_seq_cnt.sv
// Scoreboard bench: two sequencer configurations share stimulus; per-cycle expectations come from a spec-level model.
module tb_cntnet_seq_cnt;

    logic clk = 1'b0;
    logic reset, start, en;
    always #5 clk = ~clk;

    logic [2:0] cnt_a;  logic [0:0] pass_a; logic busy_a, last_a, done_a;
    logic [2:0] cnt_b;  logic [1:0] pass_b; logic busy_b, last_b, done_b;
`ifdef CNTNET_SEQ_CNT_OVERRUN_EN
    logic ovr_a, ovr_b;
`endif

    cntnet_seq_cnt dut_a (
        .clk(clk), .reset(reset), .start(start), .en(en),
        .cnt(cnt_a), .pass_idx(pass_a), .busy(busy_a), .last(last_a), .done(done_a)
`ifdef CNTNET_SEQ_CNT_OVERRUN_EN
        , .overrun(ovr_a)
`endif
    );

    cntnet_seq_cnt #(.WIDTH(3), .FIRST(2), .LAST(4), .PASSES(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .en(en),
        .cnt(cnt_b), .pass_idx(pass_b), .busy(busy_b), .last(last_b), .done(done_b)
`ifdef CNTNET_SEQ_CNT_OVERRUN_EN
        , .overrun(ovr_b)
`endif
    );

    typedef struct {
        bit run;
        int cnt;
        int pass;
        bit done;
        bit ovr;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    exp_t sb[$];
    mdl_t ma, mb;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic mdl_t nxt(mdl_t m, bit r, bit s, bit e, int first, int lst, int passes);
        mdl_t n = m;
        n.done = 1'b0;
        if (r) begin
            n = '{run: 1'b0, cnt: 0, pass: 0, done: 1'b0, ovr: 1'b0};
        end else if (s) begin
            n.ovr  = m.ovr | m.run;
            n.run  = 1'b1;
            n.cnt  = first;
            n.pass = 0;
        end else if (m.run && e) begin
            if (m.cnt < lst) n.cnt = m.cnt + 1;
            else if (m.pass < passes - 1) begin
                n.cnt  = first;
                n.pass = m.pass + 1;
            end else begin
                n.run  = 1'b0;
                n.cnt  = 0;
                n.pass = 0;
                n.done = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic step(input bit r, input bit s, input bit e);
        exp_t x;
        reset = r; start = s; en = e;
        ma = nxt(ma, r, s, e, 1, 7, 1);
        mb = nxt(mb, r, s, e, 2, 4, 3);
        sb.push_back('{a: ma, b: mb});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("a_cnt",  int'(cnt_a),  x.a.cnt);
        chk("a_pass", int'(pass_a), x.a.pass);
        chk("a_busy", int'(busy_a), int'(x.a.run));
        chk("a_done", int'(done_a), int'(x.a.done));
        chk("a_last", int'(last_a), int'(x.a.run && x.a.cnt == 7));
        chk("b_cnt",  int'(cnt_b),  x.b.cnt);
        chk("b_pass", int'(pass_b), x.b.pass);
        chk("b_busy", int'(busy_b), int'(x.b.run));
        chk("b_done", int'(done_b), int'(x.b.done));
        chk("b_last", int'(last_b), int'(x.b.run && x.b.cnt == 4 && x.b.pass == 2));
`ifdef CNTNET_SEQ_CNT_OVERRUN_EN
        chk("a_ovr",  int'(ovr_a),  int'(x.a.ovr));
        chk("b_ovr",  int'(ovr_b),  int'(x.b.ovr));
`endif
    endtask

    initial begin
        int b_seq[9] = '{2, 3, 4, 2, 3, 4, 2, 3, 4};
        int b_pas[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        reset = 1'b1; start = 1'b0; en = 1'b0;
        ma = '{run: 1'b0, cnt: 0, pass: 0, done: 1'b0, ovr: 1'b0};
        mb = ma;
        @(negedge clk);
        step(1, 0, 0);
        step(1, 1, 1);
        step(0, 0, 1);

        // T1 / T2: full sweeps with en held high
        step(0, 1, 1);
        chk("t1_cnt", int'(cnt_a), 1);
        chk("t2_cnt", int'(cnt_b), b_seq[0]);
        for (int i = 1; i < 9; i++) begin
            step(0, 0, 1);
            if (i < 7) chk("t1_cnt", int'(cnt_a), i + 1);
            if (i == 7) chk("t1_done", int'(done_a), 1);
            chk("t2_cnt",  int'(cnt_b),  b_seq[i]);
            chk("t2_pass", int'(pass_b), b_pas[i]);
            chk("t2_last", int'(last_b), int'(i == 8));
        end
        step(0, 0, 1);
        chk("t2_done", int'(done_b), 1);
        step(0, 0, 1);

        // T3: en low for 3 cycles at cnt=4
        step(0, 1, 1);
        repeat (3) step(0, 0, 1);
        chk("t3_at4", int'(cnt_a), 4);
        repeat (3) step(0, 0, 0);
        chk("t3_hold", int'(cnt_a), 4);
        step(0, 0, 1);
        chk("t3_resume", int'(cnt_a), 5);
        repeat (4) step(0, 0, 1);

        // T4: restart at cnt=5
        step(0, 1, 1);
        repeat (4) step(0, 0, 1);
        step(0, 1, 1);
        chk("t4_restart", int'(cnt_a), 1);
        repeat (8) step(0, 0, 1);

        // T5: reset with start at cnt=3
        step(0, 1, 1);
        repeat (2) step(0, 0, 1);
        step(1, 1, 1);
        chk("t5_cnt", int'(cnt_a), 0);
        chk("t5_busy", int'(busy_a), 0);

        // T6: start coincident with the final step
        step(0, 1, 1);
        repeat (6) step(0, 0, 1);
        chk("t6_at7", int'(cnt_a), 7);
        step(0, 1, 1);
        chk("t6_cnt", int'(cnt_a), 1);
        chk("t6_done", int'(done_a), 0);
        repeat (10) step(0, 0, 1);

        // Random mix
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 3) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
